// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the execute stage.
// Holds the result-class (alusel) and operation (aluop) encodings, the
// divider state enum and a small magnitude helper used by the divider.
package cpu_defs_pkg;

  localparam int DATA_W = 32;

  // Result class select
  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
  localparam logic [2:0] ALUSEL_ARITH = 3'b100;

  // Operation codes
  localparam logic [7:0] ALUOP_NOP  = 8'b0000_0000;
  localparam logic [7:0] ALUOP_AND  = 8'b0010_0100;
  localparam logic [7:0] ALUOP_OR   = 8'b0010_0101;
  localparam logic [7:0] ALUOP_XOR  = 8'b0010_0110;
  localparam logic [7:0] ALUOP_NOR  = 8'b0010_0111;
  localparam logic [7:0] ALUOP_SLL  = 8'b0111_1100;
  localparam logic [7:0] ALUOP_SRL  = 8'b0000_0010;
  localparam logic [7:0] ALUOP_SRA  = 8'b0000_0011;
  localparam logic [7:0] ALUOP_ADDU = 8'b0010_0001;
  localparam logic [7:0] ALUOP_SUBU = 8'b0010_0011;
  localparam logic [7:0] ALUOP_SLT  = 8'b0010_1010;
  localparam logic [7:0] ALUOP_SLTU = 8'b0010_1011;
  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Absolute value of a two's complement word when is_signed is set,
  // otherwise the word itself. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                            input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the execute stage (built when EX_DIV_EN
// is defined).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           a DIV/DIVU instruction sits in EX
//   signed_op       1 = DIV (signed), 0 = DIVU
//   opdata1/2       dividend / divisor, latched on the start cycle
//   cancel          flush: return to IDLE on the next edge, suppress ready
//   result          {remainder, quotient}; zero unless ready
//   ready           high during the single END cycle
//   state           current FSM state (debug / stall generation)
module ex_div
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  input  logic              cancel,
  output logic [63:0]       result,
  output logic              ready,
  output div_state_t        state
);

  div_state_t        state_q;
  logic [5:0]        cnt;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic              neg_q;
  logic              neg_r;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The partial remainder is
  // always below the divisor, so the 33-bit shifted value is below twice
  // the divisor and bit 32 of the difference is a clean borrow flag.
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quo;

  always_comb begin
    shifted  = {rem, quo[DATA_W-1]};
    diff     = shifted - {1'b0, divisor};
    step_rem = shifted[DATA_W-1:0];
    step_quo = {quo[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      step_rem = diff[DATA_W-1:0];
      step_quo = {quo[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt     <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (cancel) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            neg_q   <= signed_op & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_r   <= signed_op & opdata1[DATA_W-1];
            divisor <= mag(opdata2, signed_op);
            quo     <= mag(opdata1, signed_op);
            rem     <= '0;
            cnt     <= '0;
            state_q <= (opdata2 == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          rem     <= '0;
          quo     <= '0;
          state_q <= DIV_END;
        end
        DIV_ON: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            // Last step: apply the sign fix-up while storing the result.
            quo     <= neg_q ? (~step_quo + 32'd1) : step_quo;
            rem     <= neg_r ? (~step_rem + 32'd1) : step_rem;
            state_q <= DIV_END;
          end else begin
            quo <= step_quo;
            rem <= step_rem;
          end
        end
        DIV_END: begin
          // Always leave END so the same instruction cannot restart.
          state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign state  = state_q;
  assign ready  = (state_q == DIV_END) && !cancel;
  assign result = ready ? {rem, quo} : 64'd0;

endmodule

// File: rtl/ex_stage.sv
// Pipeline execute stage: single-cycle logic/shift/arithmetic results plus
// an optional multi-cycle DIV/DIVU unit writing HI/LO.
// Configuration macro: EX_DIV_EN. When undefined no divider is built and
// DIV/DIVU behave as undefined ops (no stall, no HI/LO write).
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   ex_reg1/ex_reg2             source operands
//   ex_wd/ex_wreg               destination index / write enable
//   ex_alusel/ex_aluop          result class / operation
//   cancel                      pipeline flush
//   wd_o/wreg_o/wdata_o         to EX/MEM
//   whilo_o/hi_o/lo_o           HI/LO write strobe, remainder, quotient
//   stallreq                    hold IF/ID/EX while a divide runs
// Divider handshake: stallreq is high from the cycle a divide is seen in
// IDLE until the END cycle; whilo_o is high only in END and is the
// completion strobe; cancel drops both in the same cycle.
module ex_stage
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_reg1,
  input  logic [DATA_W-1:0] ex_reg2,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [2:0]        ex_alusel,
  input  logic [7:0]        ex_aluop,
  input  logic              cancel,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq
);

  logic [DATA_W-1:0] alu_res;
  logic [4:0]        sh;

  assign sh = ex_reg1[4:0];

  always_comb begin
    alu_res = '0;
    case (ex_alusel)
      ALUSEL_LOGIC: begin
        case (ex_aluop)
          ALUOP_OR:  alu_res = ex_reg1 | ex_reg2;
          ALUOP_AND: alu_res = ex_reg1 & ex_reg2;
          ALUOP_XOR: alu_res = ex_reg1 ^ ex_reg2;
          ALUOP_NOR: alu_res = ~(ex_reg1 | ex_reg2);
          default:   alu_res = '0;
        endcase
      end
      ALUSEL_SHIFT: begin
        case (ex_aluop)
          ALUOP_SLL: alu_res = ex_reg2 << sh;
          ALUOP_SRL: alu_res = ex_reg2 >> sh;
          ALUOP_SRA: alu_res = $unsigned($signed(ex_reg2) >>> sh);
          default:   alu_res = '0;
        endcase
      end
      ALUSEL_ARITH: begin
        case (ex_aluop)
          ALUOP_ADDU: alu_res = ex_reg1 + ex_reg2;
          ALUOP_SUBU: alu_res = ex_reg1 - ex_reg2;
          ALUOP_SLT:  alu_res = {31'd0, $signed(ex_reg1) < $signed(ex_reg2)};
          ALUOP_SLTU: alu_res = {31'd0, ex_reg1 < ex_reg2};
          default:    alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Pass-through outputs are forced low while reset is held.
  assign wd_o    = rst ? ex_wd   : 5'd0;
  assign wreg_o  = rst ? ex_wreg : 1'b0;
  assign wdata_o = rst ? alu_res : '0;

`ifdef EX_DIV_EN
  logic       div_start;
  logic       div_signed;
  logic [63:0] div_result;
  logic       div_ready;
  div_state_t div_state;

  assign div_start  = rst && ((ex_aluop == ALUOP_DIV) || (ex_aluop == ALUOP_DIVU));
  assign div_signed = (ex_aluop == ALUOP_DIV);

  ex_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (div_signed),
    .opdata1   (ex_reg1),
    .opdata2   (ex_reg2),
    .cancel    (cancel),
    .result    (div_result),
    .ready     (div_ready),
    .state     (div_state)
  );

  assign stallreq = !cancel && ((div_state == DIV_ON) ||
                                (div_state == DIV_BY_ZERO) ||
                                ((div_state == DIV_IDLE) && div_start));
  assign whilo_o  = div_ready;
  assign hi_o     = div_result[63:32];
  assign lo_o     = div_result[31:0];
`else
  // Without the divider the clock and flush have no consumer.
  logic unused_nodiv;
  assign unused_nodiv = clk ^ cancel;

  assign stallreq = 1'b0;
  assign whilo_o  = 1'b0;
  assign hi_o     = '0;
  assign lo_o     = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import cpu_defs_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [2:0]  ex_alusel;
  logic [7:0]  ex_aluop;
  logic        cancel;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq;

  int n_vec;
  int n_fail;

  ex_stage #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_reg1   (ex_reg1),
    .ex_reg2   (ex_reg2),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_alusel (ex_alusel),
    .ex_aluop  (ex_aluop),
    .cancel    (cancel),
    .wd_o      (wd_o),
    .wreg_o    (wreg_o),
    .wdata_o   (wdata_o),
    .whilo_o   (whilo_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stallreq  (stallreq)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational ALU vector, applied and checked between clock edges.
  task automatic alu_vec(input string tag, input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    ex_alusel = sel;
    ex_aluop  = op;
    ex_reg1   = a;
    ex_reg2   = b;
    #1;
    chk(tag, wdata_o, exp);
    chk({tag, "_stall"}, {31'd0, stallreq}, 32'd0);
  endtask

`ifdef EX_DIV_EN
  // Starts a divide, scrambles the operand inputs mid-run, and checks stall
  // length, the single END cycle and the return to quiet outputs.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    @(negedge clk);
    ex_alusel = ALUSEL_NOP;
    ex_aluop  = op;
    ex_reg1   = a;
    ex_reg2   = b;
    #1;
    n = 0;
    while (stallreq && n < 40) begin
      n++;
      if (n == 3) begin
        ex_reg1 = $urandom_range(32'h7FFF_FFFF, 1);
        ex_reg2 = $urandom_range(32'h7FFF_FFFF, 1);
      end
      @(negedge clk);
      #1;
    end
    chk({tag, "_stalls"}, n, exp_stalls);
    chk({tag, "_whilo"}, {31'd0, whilo_o}, 32'd1);
    chk({tag, "_lo"}, lo_o, exp_lo);
    chk({tag, "_hi"}, hi_o, exp_hi);
    ex_aluop = ALUOP_NOP;
    @(negedge clk);
    #1;
    chk({tag, "_whilo_after"}, {31'd0, whilo_o}, 32'd0);
    chk({tag, "_lo_after"}, lo_o, 32'd0);
  endtask
`endif

  initial begin
    logic saw;
    n_vec     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    ex_alusel = ALUSEL_LOGIC;
    ex_aluop  = ALUOP_OR;
    ex_reg1   = 32'h0000_F0F0;
    ex_reg2   = 32'h00FF_0000;
    ex_wd     = 5'h1F;
    ex_wreg   = 1'b1;
    cancel    = 1'b0;

    // Reset state: outputs low regardless of inputs
    #3;
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_stall", {31'd0, stallreq}, 32'd0);
    chk("rst_whilo", {31'd0, whilo_o}, 32'd0);
    chk("rst_hilo", hi_o | lo_o, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ori_wdata", wdata_o, 32'h00FF_F0F0);
    chk("ori_wd", {27'd0, wd_o}, 32'h1F);
    chk("ori_wreg", {31'd0, wreg_o}, 32'd1);
    chk("ori_stall", {31'd0, stallreq}, 32'd0);

    // Single-cycle operations
    alu_vec("and",  ALUSEL_LOGIC, ALUOP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_vec("xor",  ALUSEL_LOGIC, ALUOP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu_vec("nor",  ALUSEL_LOGIC, ALUOP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
    alu_vec("sll",  ALUSEL_SHIFT, ALUOP_SLL,  32'h0000_0004, 32'h0000_00F1, 32'h0000_0F10);
    alu_vec("sll_amt5", ALUSEL_SHIFT, ALUOP_SLL, 32'h0000_0025, 32'h0000_0001, 32'h0000_0020);
    alu_vec("srl",  ALUSEL_SHIFT, ALUOP_SRL,  32'h0000_0008, 32'h8000_0000, 32'h0080_0000);
    alu_vec("sra",  ALUSEL_SHIFT, ALUOP_SRA,  32'h0000_0008, 32'h8000_0000, 32'hFF80_0000);
    alu_vec("sra31", ALUSEL_SHIFT, ALUOP_SRA, 32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF);
    alu_vec("addu_wrap", ALUSEL_ARITH, ALUOP_ADDU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    alu_vec("subu_wrap", ALUSEL_ARITH, ALUOP_SUBU, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    alu_vec("slt",  ALUSEL_ARITH, ALUOP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu_vec("sltu", ALUSEL_ARITH, ALUOP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu_vec("nop",  ALUSEL_NOP,   ALUOP_OR,   32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000);
    alu_vec("undef", ALUSEL_LOGIC, ALUOP_ADDU, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);

`ifdef EX_DIV_EN
    run_div("divu_100_7", ALUOP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div_m7_2", ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_min_m1", ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_div("divu_big", ALUOP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0FFF_FFFF, 32'h0000_000F);
    run_div("div_5_0", ALUOP_DIV, 32'd5, 32'd0, 2, 32'd0, 32'd0);

    // Cancel at ON step 10
    @(negedge clk);
    ex_aluop = ALUOP_DIVU;
    ex_reg1  = 32'd1000;
    ex_reg2  = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    chk("cancel_pre_stall", {31'd0, stallreq}, 32'd1);
    cancel = 1'b1;
    #1;
    chk("cancel_stall", {31'd0, stallreq}, 32'd0);
    chk("cancel_whilo", {31'd0, whilo_o}, 32'd0);
    ex_aluop = ALUOP_NOP;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    chk("cancel_idle_stall", {31'd0, stallreq}, 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      saw = saw | whilo_o | stallreq;
    end
    chk("cancel_no_pulse", {31'd0, saw}, 32'd0);
    run_div("divu_9_3", ALUOP_DIVU, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    // Asynchronous reset mid-divide
    @(negedge clk);
    ex_aluop = ALUOP_DIVU;
    ex_reg1  = 32'd100;
    ex_reg2  = 32'd7;
    ex_wd    = 5'd3;
    ex_wreg  = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stallreq}, 32'd0);
    chk("arst_whilo", {31'd0, whilo_o}, 32'd0);
    chk("arst_hilo", hi_o | lo_o, 32'd0);
    chk("arst_wd", {27'd0, wd_o}, 32'd0);
    chk("arst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("arst_wdata", wdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ex_aluop = ALUOP_NOP;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      saw = saw | whilo_o;
    end
    chk("arst_no_pulse", {31'd0, saw}, 32'd0);
    run_div("divu_after_rst", ALUOP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2);
`else
    // Divider absent: DIVU is an undefined op
    @(negedge clk);
    ex_alusel = ALUSEL_NOP;
    ex_aluop  = ALUOP_DIVU;
    ex_reg1   = 32'd100;
    ex_reg2   = 32'd7;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      saw = saw | stallreq;
      @(negedge clk);
    end
    chk("nodiv_stall", {31'd0, saw}, 32'd0);
    chk("nodiv_whilo", {31'd0, whilo_o}, 32'd0);
    chk("nodiv_hilo", hi_o | lo_o, 32'd0);
    chk("nodiv_wdata", wdata_o, 32'd0);

    // Asynchronous reset clears the pass-through outputs
    ex_wd   = 5'd3;
    ex_wreg = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wd", {27'd0, wd_o}, 32'd0);
    chk("arst_wreg", {31'd0, wreg_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_wd", {27'd0, wd_o}, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
